// File: rtl/seg_scan_driver_if.sv
// Display data in, multiplexed segment/tube drive out.
interface seg_scan_driver_if;
  logic [31:0] time_data;
  logic [7:0]  blink_mask;
  logic [7:0]  digit1;
  logic [7:0]  digit2;
  logic [7:0]  tube_sel;

  modport master (
    output time_data,
    output blink_mask,
    input  digit1,
    input  digit2,
    input  tube_sel
  );

  modport slave (
    input  time_data,
    input  blink_mask,
    output digit1,
    output digit2,
    output tube_sel
  );
endinterface

// File: rtl/seg_scan_driver.sv
// Eight-tube seven-segment scan driver: two groups of four tubes are scanned in
// parallel, one tube per group per step, from a per-frame snapshot with blinking.
module seg_scan_driver #(
  parameter int unsigned SCAN_DIV  = 100_000,
  parameter int unsigned BLINK_DIV = 50_000_000
) (
  input logic             clk,
  input logic             rst,
  seg_scan_driver_if.slave bus
);

  localparam int unsigned ScanW  = (SCAN_DIV > 1) ? $clog2(SCAN_DIV) : 1;
  localparam int unsigned BlinkW = (BLINK_DIV > 1) ? $clog2(BLINK_DIV) : 1;
  localparam logic [ScanW-1:0]  ScanLast  = ScanW'(SCAN_DIV - 1);
  localparam logic [BlinkW-1:0] BlinkLast = BlinkW'(BLINK_DIV - 1);

  logic [ScanW-1:0]  scan_cnt_q, scan_cnt_d;
  logic [BlinkW-1:0] blink_cnt_q, blink_cnt_d;
  logic              blink_phase_q, blink_phase_d;
  logic [1:0]        idx_q, idx_d;
  logic [31:0]       frame_data_q, frame_data_d;
  logic [7:0]        frame_mask_q, frame_mask_d;
  logic [7:0]        digit1_q, digit1_d;
  logic [7:0]        digit2_q, digit2_d;
  logic [7:0]        tube_sel_q, tube_sel_d;

  logic       scan_tick;
  logic       blink_wrap;
  logic [2:0] left_pos;
  logic [2:0] right_pos;
  logic [3:0] left_nib;
  logic [3:0] right_nib;

  // Segment order a..g,dp on bits 7..0; codes A..E blank, F is a dash.
  function automatic logic [7:0] seg_decode(input logic [3:0] code);
    logic [7:0] seg;
    case (code)
      4'h0:    seg = 8'b1111_1100;
      4'h1:    seg = 8'b0110_0000;
      4'h2:    seg = 8'b1101_1010;
      4'h3:    seg = 8'b1111_0010;
      4'h4:    seg = 8'b0110_0110;
      4'h5:    seg = 8'b1011_0110;
      4'h6:    seg = 8'b1011_1110;
      4'h7:    seg = 8'b1110_0000;
      4'h8:    seg = 8'b1111_1110;
      4'h9:    seg = 8'b1111_0110;
      4'hF:    seg = 8'b0000_0010;
      default: seg = 8'h00;
    endcase
    return seg;
  endfunction

  // Counters, frame snapshot and the registered display step.
  always_comb begin
    scan_tick     = (scan_cnt_q == ScanLast);
    scan_cnt_d    = scan_tick ? '0 : scan_cnt_q + 1'b1;
    blink_wrap    = (blink_cnt_q == BlinkLast);
    blink_cnt_d   = blink_wrap ? '0 : blink_cnt_q + 1'b1;
    blink_phase_d = blink_phase_q ^ blink_wrap;
    idx_d         = scan_tick ? idx_q + 2'd1 : idx_q;

    // idx_q is the step shown at the next tick; step 0 takes a fresh snapshot
    // which is used in the same tick so step 0 already shows the new frame.
    frame_data_d = frame_data_q;
    frame_mask_d = frame_mask_q;
    if (scan_tick && (idx_q == 2'd0)) begin
      frame_data_d = bus.time_data;
      frame_mask_d = bus.blink_mask;
    end

    left_pos  = 3'd7 - {1'b0, idx_q};
    right_pos = 3'd3 - {1'b0, idx_q};
    left_nib  = frame_data_d[{left_pos, 2'b00} +: 4];
    right_nib = frame_data_d[{right_pos, 2'b00} +: 4];

    digit1_d   = digit1_q;
    digit2_d   = digit2_q;
    tube_sel_d = tube_sel_q;
    if (scan_tick) begin
      tube_sel_d            = '0;
      tube_sel_d[left_pos]  = 1'b1;
      tube_sel_d[right_pos] = 1'b1;
      digit1_d = (!blink_phase_q && frame_mask_d[left_pos])  ? 8'h00 : seg_decode(left_nib);
      digit2_d = (!blink_phase_q && frame_mask_d[right_pos]) ? 8'h00 : seg_decode(right_nib);
    end
  end

  // State registers with asynchronous active-low clear.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      scan_cnt_q    <= '0;
      blink_cnt_q   <= '0;
      blink_phase_q <= 1'b1;
      idx_q         <= 2'd0;
      frame_data_q  <= 32'hFFFF_FFFF;
      frame_mask_q  <= 8'h00;
      digit1_q      <= 8'h00;
      digit2_q      <= 8'h00;
      tube_sel_q    <= 8'h00;
    end else begin
      scan_cnt_q    <= scan_cnt_d;
      blink_cnt_q   <= blink_cnt_d;
      blink_phase_q <= blink_phase_d;
      idx_q         <= idx_d;
      frame_data_q  <= frame_data_d;
      frame_mask_q  <= frame_mask_d;
      digit1_q      <= digit1_d;
      digit2_q      <= digit2_d;
      tube_sel_q    <= tube_sel_d;
    end
  end

  assign bus.digit1   = digit1_q;
  assign bus.digit2   = digit2_q;
  assign bus.tube_sel = tube_sel_q;

endmodule
